lz_denormalizer: RTL

Multi-cycle right-shifter that undoes leading-zero normalization. It accepts a normalized word (MSB set) and the leading-zero count produced by the priority-encoder path. It then rebuilds the original word, so that its leading-zero count equals the supplied count. It sits on the unpack side of the normalization datapath and uses valid/ready handshakes on both sides.

---
 rtl/lz_pkg.sv | 16 +
 rtl/lz_shift_stage.sv | 27 ++
 rtl/lz_denormalizer.sv | 100 ++++++++++
 3 files changed

// File: rtl/lz_pkg.sv
// Shared definitions for the leading-zero normalization datapath.
// Holds the denormalizer state type and the count-width helper used by encoder and denormalizer.
package lz_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } lz_dn_state_t;

    // A count of w leading zeros (an all-zero word) needs one bit more than $clog2(w).
    function automatic int lz_cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/lz_shift_stage.sv
// One conditional logarithmic shifter stage: right shift by 2^k with zero fill.
// Shift amounts that reach or exceed the word width clear the word rather than wrapping.
module lz_shift_stage #(
    parameter int DATA_WIDTH = 8,
    parameter int K_WIDTH    = 2
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [K_WIDTH-1:0]    k,
    input  logic                  en,
    output logic [DATA_WIDTH-1:0] result
);

    logic [31:0] amount;

    always_comb begin
        amount = 32'd1 << k;
        result = data;
        if (en) begin
            if (amount >= 32'(DATA_WIDTH)) begin
                result = '0;
            end else begin
                result = data >> amount;
            end
        end
    end

endmodule

// File: rtl/lz_denormalizer.sv
// Multi-cycle right shifter that undoes leading-zero normalization, one count bit per cycle.
// Requests and results use valid/ready handshakes; inconsistent requests are flagged on out_err.
module lz_denormalizer
    import lz_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    localparam int CNT_WIDTH  = lz_cnt_width(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_norm,
    input  logic [CNT_WIDTH-1:0]  in_cnt,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_err
);

    localparam int                  K_WIDTH = $clog2(CNT_WIDTH);
    localparam logic [K_WIDTH-1:0]  LAST_K  = K_WIDTH'(CNT_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] DW_CNT = CNT_WIDTH'(DATA_WIDTH);

    lz_dn_state_t          state_q;
    lz_dn_state_t          state_d;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] stage_out;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [K_WIDTH-1:0]    k_q;
    logic                  err_q;
    logic                  over_range;
    logic                  req_err;

    assign over_range = in_cnt > DW_CNT;
    assign req_err    = over_range || ((in_cnt < DW_CNT) && !in_norm[DATA_WIDTH-1]);

    // The count register is consumed LSB-first, so bit 0 always enables the current stage k.
    lz_shift_stage #(
        .DATA_WIDTH (DATA_WIDTH),
        .K_WIDTH    (K_WIDTH)
    ) u_stage (
        .data   (shift_q),
        .k      (k_q),
        .en     (cnt_q[0]),
        .result (stage_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid)        state_d = SHIFT;
            SHIFT:   if (k_q == LAST_K)   state_d = DONE;
            DONE:    if (out_ready)       state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
    end

    // Out-of-range counts load zero so the result is zero regardless of which stages fire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
            k_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        shift_q <= over_range ? '0 : in_norm;
                        cnt_q   <= in_cnt;
                        k_q     <= '0;
                        err_q   <= req_err;
                    end
                end
                SHIFT: begin
                    shift_q <= stage_out;
                    cnt_q   <= cnt_q >> 1;
                    k_q     <= (k_q == LAST_K) ? '0 : k_q + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = out_valid ? shift_q : '0;
    assign out_err   = out_valid & err_q;

endmodule
